// File: rtl/sirv_qspi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sirv_qspi_frame_ctrl
// Purpose  : QSPI frame controller. It turns byte-level link requests into
//            physical-layer micro-ops: CS-to-SCK delay, transfer, inter-
//            transfer delay, SCK-to-CS delay and inter-CS delay. It also
//            drives the chip selects and returns one RX byte per transfer.
// Ports    : clock/reset         core clock, async active-high reset
//            io_link_*           request in (valid/ready/data/cnt/cs_hold),
//                                RX byte out (rx_valid pulse / rx_bits)
//            io_cs_mode/id/dflt  chip-select mode, index, inactive levels
//            io_dly_*            delay lengths in SCK ticks
//            io_port_cs          chip-select lines
//            io_op_*             micro-op port to the physical layer
//            io_rx_valid/bits    physical-layer done level and RX byte
// Revision : 1.0 - initial release
// ============================================================================
module sirv_qspi_frame_ctrl #(
    parameter int CS_WIDTH    = 1,
    parameter int CS_ID_WIDTH = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_link_valid,
    output logic                   io_link_ready,
    input  logic [7:0]             io_link_data,
    input  logic [7:0]             io_link_cnt,
    input  logic                   io_link_cs_hold,
    output logic                   io_link_rx_valid,
    output logic [7:0]             io_link_rx_bits,
    input  logic [1:0]             io_cs_mode,
    input  logic [CS_ID_WIDTH-1:0] io_cs_id,
    input  logic [CS_WIDTH-1:0]    io_cs_dflt,
    input  logic [7:0]             io_dly_cssck,
    input  logic [7:0]             io_dly_sckcs,
    input  logic [7:0]             io_dly_intercs,
    input  logic [7:0]             io_dly_interxfr,
    output logic [CS_WIDTH-1:0]    io_port_cs,
    output logic                   io_op_valid,
    input  logic                   io_op_ready,
    output logic                   io_op_fn,
    output logic                   io_op_stb,
    output logic [7:0]             io_op_cnt,
    output logic [7:0]             io_op_data,
    input  logic                   io_rx_valid,
    input  logic [7:0]             io_rx_bits
);

    localparam logic [1:0] MODE_HOLD = 2'd2;
    localparam logic [1:0] MODE_OFF  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CSSCK    = 3'd1,
        S_XFER     = 3'd2,
        S_INTERXFR = 3'd3,
        S_WAIT     = 3'd4,
        S_SCKCS    = 3'd5,
        S_CSOFF    = 3'd6,
        S_INTERCS  = 3'd7
    } state_e;

    state_e                 state_q, state_d;
    logic                   cs_act_q, cs_act_d;
    logic                   hold_q, hold_d;
    logic                   rx_pending_q, rx_pending_d;
    logic [CS_ID_WIDTH-1:0] cs_id_q, cs_id_d;
    logic                   rx_valid_q;
    logic [7:0]             rx_bits_q;

    logic                   w_xfer_fire;
    logic                   w_rx_capture;
    logic                   w_mode_off;
    logic                   w_mode_auto;
    logic [CS_WIDTH-1:0]    w_cs_sel;

    // Mode encoding 1 behaves as AUTO, so AUTO is simply "bit 1 clear".
    assign w_mode_off  = (io_cs_mode == MODE_OFF);
    assign w_mode_auto = ~io_cs_mode[1];

    // One-hot decode of the captured CS index; indices beyond CS_WIDTH
    // select nothing.
    for (genvar g = 0; g < CS_WIDTH; g++) begin : g_cs_sel
        assign w_cs_sel[g] = (cs_id_q == CS_ID_WIDTH'(g));
    end

    // Purely a function of async-reset registers, so CS returns to its
    // inactive level the moment reset asserts.
    assign io_port_cs = io_cs_dflt ^ (cs_act_q ? w_cs_sel : '0);

    always_comb begin
        state_d       = state_q;
        cs_act_d      = cs_act_q;
        hold_d        = hold_q;
        cs_id_d       = cs_id_q;
        io_op_valid   = 1'b0;
        io_op_fn      = 1'b0;
        io_op_stb     = 1'b0;
        io_op_cnt     = 8'd0;
        io_op_data    = 8'd0;
        io_link_ready = 1'b0;
        w_xfer_fire   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cs_act_d = 1'b0;
                if (io_link_valid) begin
                    cs_id_d = io_cs_id;
                    if (w_mode_off) begin
                        state_d = S_XFER;
                    end else begin
                        cs_act_d = 1'b1;
                        state_d  = S_CSSCK;
                    end
                end
            end
            S_CSSCK: begin
                io_op_valid = 1'b1;
                io_op_fn    = 1'b1;
                io_op_stb   = 1'b1;
                io_op_cnt   = io_dly_cssck;
                if (io_op_ready) state_d = S_XFER;
            end
            S_XFER: begin
                io_op_valid   = io_link_valid;
                io_op_stb     = 1'b1;
                io_op_cnt     = io_link_cnt;
                io_op_data    = io_link_data;
                io_link_ready = io_op_ready;
                if (io_link_valid && io_op_ready) begin
                    w_xfer_fire = 1'b1;
                    hold_d      = io_link_cs_hold;
                    if (w_mode_off) begin
                        // IDLE never keeps CS asserted.
                        cs_act_d = 1'b0;
                        state_d  = S_IDLE;
                    end else if ((io_cs_mode == MODE_HOLD) || io_link_cs_hold) begin
                        state_d = S_INTERXFR;
                    end else begin
                        state_d = S_SCKCS;
                    end
                end
            end
            S_INTERXFR: begin
                io_op_valid = 1'b1;
                io_op_fn    = 1'b1;
                io_op_cnt   = io_dly_interxfr;
                if (io_op_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A new byte wins over releasing the chip select.
                if (io_link_valid) begin
                    state_d = S_XFER;
                end else if (w_mode_off || (w_mode_auto && !hold_q)) begin
                    state_d = S_SCKCS;
                end
            end
            S_SCKCS: begin
                io_op_valid = 1'b1;
                io_op_fn    = 1'b1;
                io_op_cnt   = io_dly_sckcs;
                if (io_op_ready) state_d = S_CSOFF;
            end
            S_CSOFF: begin
                // Release CS only once the SCK-to-CS delay has fully run out.
                if (io_op_ready) begin
                    cs_act_d = 1'b0;
                    state_d  = S_INTERCS;
                end
            end
            S_INTERCS: begin
                io_op_valid = 1'b1;
                io_op_fn    = 1'b1;
                io_op_cnt   = io_dly_intercs;
                if (io_op_ready) state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                cs_act_d = 1'b0;
            end
        endcase
    end

    // The previous transfer's byte may be collected on the same edge a new
    // transfer is accepted; the new transfer's pending flag must survive.
    assign w_rx_capture = rx_pending_q && io_op_ready && io_rx_valid;

    always_comb begin
        rx_pending_d = rx_pending_q;
        if (w_rx_capture) rx_pending_d = 1'b0;
        if (w_xfer_fire)  rx_pending_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cs_act_q     <= 1'b0;
            hold_q       <= 1'b0;
            rx_pending_q <= 1'b0;
            cs_id_q      <= '0;
            rx_valid_q   <= 1'b0;
            rx_bits_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            cs_act_q     <= cs_act_d;
            hold_q       <= hold_d;
            rx_pending_q <= rx_pending_d;
            cs_id_q      <= cs_id_d;
            rx_valid_q   <= w_rx_capture;
            if (w_rx_capture) rx_bits_q <= io_rx_bits;
        end
    end

    assign io_link_rx_valid = rx_valid_q;
    assign io_link_rx_bits  = rx_bits_q;

endmodule
`default_nettype wire

// File: tb/tb_sirv_qspi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sirv_qspi_frame_ctrl
// Purpose  : Directed self-checking bench for sirv_qspi_frame_ctrl with a
//            small physical-layer model that returns ~data as the RX byte.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sirv_qspi_frame_ctrl;

    localparam int CSW  = 2;
    localparam int CSIW = 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            io_link_valid, io_link_ready;
    logic [7:0]      io_link_data, io_link_cnt;
    logic            io_link_cs_hold;
    logic            io_link_rx_valid;
    logic [7:0]      io_link_rx_bits;
    logic [1:0]      io_cs_mode;
    logic [CSIW-1:0] io_cs_id;
    logic [CSW-1:0]  io_cs_dflt;
    logic [7:0]      io_dly_cssck, io_dly_sckcs, io_dly_intercs, io_dly_interxfr;
    logic [CSW-1:0]  io_port_cs;
    logic            io_op_valid, io_op_ready, io_op_fn, io_op_stb;
    logic [7:0]      io_op_cnt, io_op_data;
    logic            io_rx_valid;
    logic [7:0]      io_rx_bits;

    always #5 clock = ~clock;

    sirv_qspi_frame_ctrl #(.CS_WIDTH(CSW), .CS_ID_WIDTH(CSIW)) dut (
        .clock(clock), .reset(reset),
        .io_link_valid(io_link_valid), .io_link_ready(io_link_ready),
        .io_link_data(io_link_data), .io_link_cnt(io_link_cnt),
        .io_link_cs_hold(io_link_cs_hold),
        .io_link_rx_valid(io_link_rx_valid), .io_link_rx_bits(io_link_rx_bits),
        .io_cs_mode(io_cs_mode), .io_cs_id(io_cs_id), .io_cs_dflt(io_cs_dflt),
        .io_dly_cssck(io_dly_cssck), .io_dly_sckcs(io_dly_sckcs),
        .io_dly_intercs(io_dly_intercs), .io_dly_interxfr(io_dly_interxfr),
        .io_port_cs(io_port_cs),
        .io_op_valid(io_op_valid), .io_op_ready(io_op_ready),
        .io_op_fn(io_op_fn), .io_op_stb(io_op_stb),
        .io_op_cnt(io_op_cnt), .io_op_data(io_op_data),
        .io_rx_valid(io_rx_valid), .io_rx_bits(io_rx_bits)
    );

    // Physical-layer model: busy for cnt+1 cycles per op, done level when idle.
    logic [8:0] phy_busy = 9'd0;
    logic [7:0] phy_rx   = 8'd0;
    logic       phy_en;

    assign io_op_ready = phy_en && (phy_busy == 9'd0);
    assign io_rx_valid = (phy_busy == 9'd0);
    assign io_rx_bits  = phy_rx;

    always @(posedge clock) begin
        if (io_op_valid && io_op_ready) begin
            phy_busy <= {1'b0, io_op_cnt} + 9'd1;
            if (!io_op_fn) phy_rx <= ~io_op_data;
        end else if (phy_busy != 9'd0) begin
            phy_busy <= phy_busy - 9'd1;
        end
    end

    // Monitor: accepted ops (with CS level at accept), RX pulses, CS edges.
    logic [17:0]    op_log [0:63];
    logic [CSW-1:0] op_cs  [0:63];
    logic [7:0]     rx_log [0:15];
    int             n_ops   = 0;
    int             n_rx    = 0;
    int             n_edges = 0;
    logic [CSW-1:0] cs_prev = 2'b11;

    always @(posedge clock) begin
        if (io_op_valid && io_op_ready && n_ops < 64) begin
            op_log[n_ops] <= {io_op_fn, io_op_stb, io_op_cnt, io_op_fn ? 8'h00 : io_op_data};
            op_cs[n_ops]  <= io_port_cs;
            n_ops         <= n_ops + 1;
        end
        if (io_link_rx_valid && n_rx < 16) begin
            rx_log[n_rx] <= io_link_rx_bits;
            n_rx         <= n_rx + 1;
        end
        if (io_port_cs != cs_prev) n_edges <= n_edges + 1;
        cs_prev <= io_port_cs;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] op(input logic fn, input logic stb,
                                       input logic [7:0] cnt, input logic [7:0] data);
        return {fn, stb, cnt, data};
    endfunction

    task automatic chk_op(input int idx, input logic [17:0] e, input logic [CSW-1:0] ecs);
        check($sformatf("op%0d", idx), {14'd0, op_log[idx]}, {14'd0, e});
        check($sformatf("op%0d_cs", idx), {30'd0, op_cs[idx]}, {30'd0, ecs});
    endtask

    task automatic wait_ops(input int n);
        int t = 0;
        while (n_ops < n && t < 500) begin
            @(negedge clock);
            t++;
        end
        check($sformatf("ops_reached_%0d", n), (n_ops >= n), 1);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] c, input logic h);
        int t = 0;
        io_link_valid   = 1'b1;
        io_link_data    = d;
        io_link_cnt     = c;
        io_link_cs_hold = h;
        while (!io_link_ready && t < 500) begin
            @(negedge clock);
            t++;
        end
        check("link_accept", io_link_ready, 1);
        @(negedge clock);
        io_link_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (30) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, r, ed;
        reset = 1'b1;
        io_link_valid = 1'b0; io_link_data = 8'h00; io_link_cnt = 8'h00; io_link_cs_hold = 1'b0;
        io_cs_mode = 2'd0; io_cs_id = 1'b0; io_cs_dflt = 2'b11;
        io_dly_cssck = 8'd2; io_dly_sckcs = 8'd3; io_dly_intercs = 8'd1; io_dly_interxfr = 8'd4;
        phy_en = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_op_valid", io_op_valid, 0);
        check("rst_link_ready", io_link_ready, 0);
        check("rst_rx_valid", io_link_rx_valid, 0);
        check("rst_rx_bits", io_link_rx_bits, 0);
        check("rst_cs", io_port_cs, 2'b11);
        reset = 1'b0;
        @(negedge clock);

        // AUTO, single byte
        b = n_ops; r = n_rx; ed = n_edges;
        send(8'hA5, 8'd8, 1'b0);
        wait_ops(b + 4);
        settle();
        chk_op(b + 0, op(1, 1, 8'd2, 8'h00), 2'b10);
        chk_op(b + 1, op(0, 1, 8'd8, 8'hA5), 2'b10);
        chk_op(b + 2, op(1, 0, 8'd3, 8'h00), 2'b10);
        chk_op(b + 3, op(1, 0, 8'd1, 8'h00), 2'b11);
        check("t1_nops", n_ops, b + 4);
        check("t1_nrx", n_rx, r + 1);
        check("t1_rx0", rx_log[r], 8'h5A);
        check("t1_cs_edges", n_edges - ed, 2);
        check("t1_cs_end", io_port_cs, 2'b11);

        // AUTO, three bytes with cs_hold 1,1,0
        b = n_ops; r = n_rx; ed = n_edges;
        send(8'h11, 8'd8, 1'b1);
        send(8'h22, 8'd8, 1'b1);
        send(8'h33, 8'd8, 1'b0);
        wait_ops(b + 8);
        settle();
        chk_op(b + 0, op(1, 1, 8'd2, 8'h00), 2'b10);
        chk_op(b + 1, op(0, 1, 8'd8, 8'h11), 2'b10);
        chk_op(b + 2, op(1, 0, 8'd4, 8'h00), 2'b10);
        chk_op(b + 3, op(0, 1, 8'd8, 8'h22), 2'b10);
        chk_op(b + 4, op(1, 0, 8'd4, 8'h00), 2'b10);
        chk_op(b + 5, op(0, 1, 8'd8, 8'h33), 2'b10);
        chk_op(b + 6, op(1, 0, 8'd3, 8'h00), 2'b10);
        chk_op(b + 7, op(1, 0, 8'd1, 8'h00), 2'b11);
        check("t2_nops", n_ops, b + 8);
        check("t2_nrx", n_rx, r + 3);
        check("t2_rx0", rx_log[r + 0], 8'hEE);
        check("t2_rx1", rx_log[r + 1], 8'hDD);
        check("t2_rx2", rx_log[r + 2], 8'hCC);
        check("t2_cs_edges", n_edges - ed, 2);

        // HOLD, two bytes, idle, then switch to AUTO
        io_cs_mode = 2'd2;
        b = n_ops; r = n_rx;
        send(8'h44, 8'd8, 1'b0);
        send(8'h55, 8'd8, 1'b0);
        repeat (50) @(negedge clock);
        check("t3_nops_held", n_ops, b + 5);
        check("t3_cs_held", io_port_cs, 2'b10);
        check("t3_nrx", n_rx, r + 2);
        chk_op(b + 2, op(1, 0, 8'd4, 8'h00), 2'b10);
        chk_op(b + 4, op(1, 0, 8'd4, 8'h00), 2'b10);
        io_cs_mode = 2'd0;
        wait_ops(b + 7);
        settle();
        chk_op(b + 5, op(1, 0, 8'd3, 8'h00), 2'b10);
        chk_op(b + 6, op(1, 0, 8'd1, 8'h00), 2'b11);
        check("t3_cs_end", io_port_cs, 2'b11);

        // OFF mode
        io_cs_mode = 2'd3;
        b = n_ops; r = n_rx; ed = n_edges;
        send(8'h66, 8'd8, 1'b0);
        wait_ops(b + 1);
        settle();
        chk_op(b, op(0, 1, 8'd8, 8'h66), 2'b11);
        check("t4_nops", n_ops, b + 1);
        check("t4_cs_edges", n_edges - ed, 0);
        check("t4_nrx", n_rx, r + 1);
        check("t4_rx0", rx_log[r], 8'h99);
        io_cs_mode = 2'd0;

        // CS id 1, changed to 0 mid-frame
        io_cs_id = 1'b1;
        b = n_ops;
        send(8'h77, 8'd8, 1'b1);
        io_cs_id = 1'b0;
        send(8'h88, 8'd8, 1'b0);
        wait_ops(b + 6);
        settle();
        chk_op(b + 0, op(1, 1, 8'd2, 8'h00), 2'b01);
        chk_op(b + 1, op(0, 1, 8'd8, 8'h77), 2'b01);
        chk_op(b + 3, op(0, 1, 8'd8, 8'h88), 2'b01);
        chk_op(b + 4, op(1, 0, 8'd3, 8'h00), 2'b01);
        chk_op(b + 5, op(1, 0, 8'd1, 8'h00), 2'b11);
        send(8'h99, 8'd8, 1'b0);
        wait_ops(b + 10);
        settle();
        chk_op(b + 6, op(1, 1, 8'd2, 8'h00), 2'b10);
        chk_op(b + 7, op(0, 1, 8'd8, 8'h99), 2'b10);

        // Zero delay and zero-beat transfer
        io_dly_cssck = 8'd0;
        b = n_ops; r = n_rx;
        send(8'hC3, 8'd0, 1'b0);
        wait_ops(b + 4);
        settle();
        chk_op(b + 0, op(1, 1, 8'd0, 8'h00), 2'b10);
        chk_op(b + 1, op(0, 1, 8'd0, 8'hC3), 2'b10);
        check("t7_nrx", n_rx, r + 1);
        check("t7_rx0", rx_log[r], 8'h3C);
        io_dly_cssck = 8'd2;

        // Reset during a stalled transfer
        b = n_ops; r = n_rx;
        io_link_valid = 1'b1; io_link_data = 8'hAB; io_link_cnt = 8'd8; io_link_cs_hold = 1'b0;
        wait_ops(b + 1);
        phy_en = 1'b0;
        @(negedge clock);
        check("t6_stall_valid", io_op_valid, 1);
        check("t6_stall_fn", io_op_fn, 0);
        check("t6_stall_data", io_op_data, 8'hAB);
        check("t6_stall_cs", io_port_cs, 2'b10);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", io_op_valid, 0);
        check("t6_rst_cs", io_port_cs, 2'b11);
        check("t6_rst_ready", io_link_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t6_no_rx", n_rx, r);
        phy_en = 1'b1;
        send(8'hAB, 8'd8, 1'b0);
        wait_ops(b + 5);
        settle();
        chk_op(b + 1, op(1, 1, 8'd2, 8'h00), 2'b10);
        chk_op(b + 2, op(0, 1, 8'd8, 8'hAB), 2'b10);
        chk_op(b + 3, op(1, 0, 8'd3, 8'h00), 2'b10);
        chk_op(b + 4, op(1, 0, 8'd1, 8'h00), 2'b11);
        check("t6_nrx", n_rx, r + 1);
        check("t6_rx0", rx_log[r], 8'h54);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
